// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin output arbiter.
// No logic: state encoding and index-width function only.
// Imported by rr_pick and mux_rr_arbiter.
package mux_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_SEND = 1'b1
    } arb_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search starting just after the previous winner.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           req,
    input  logic [idx_w(N)-1:0]    last,
    output logic                   any,
    output logic [idx_w(N)-1:0]    win
);

    localparam int IDX_W = idx_w(N);

    logic [IDX_W-1:0] start;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    always_comb begin
        start = (last == IDX_W'(N - 1)) ? '0 : last + IDX_W'(1);
        // Rotate so the highest-priority index lands at bit 0.
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        sum = {1'b0, off} + {1'b0, start};
        if (sum >= (IDX_W + 1)'(N)) begin
            sum = sum - (IDX_W + 1)'(N);
        end
        win = sum[IDX_W-1:0];
        any = |req;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Shares one registered output word between N requesters, round-robin.
// Latency: word accepted in cycle t is on out_data in cycle t+1.
// Backpressure: out_ready low while full holds everything and drops req_ready.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req_valid,
    input  logic [N*W-1:0]         req_data,
    output logic [N-1:0]           req_ready,
    output logic                   out_valid,
    output logic [W-1:0]           out_data,
    input  logic                   out_ready,
    output logic [idx_w(N)-1:0]    grant_idx
);

    localparam int IDX_W = idx_w(N);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] last;
    logic             any;
    logic [IDX_W-1:0] win;
    logic             free;
    logic             xfer;
    logic [W-1:0]     mux_dat;

    rr_pick #(.N(N)) u_pick (
        .req  (req_valid),
        .last (last),
        .any  (any),
        .win  (win)
    );

    assign mux_dat   = req_data[win*W +: W];
    assign out_valid = (state == ARB_SEND);

    always_comb begin
        // Ready is held low while in reset so nothing looks accepted.
        free      = rst_n & ((state == ARB_IDLE) | out_ready);
        xfer      = free & any;
        req_ready = '0;
        if (xfer) begin
            req_ready[win] = 1'b1;
        end
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (xfer) state_nxt = ARB_SEND;
            end
            ARB_SEND: begin
                if (xfer)           state_nxt = ARB_SEND;
                else if (out_ready) state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            last      <= IDX_W'(N - 1);
            out_data  <= '0;
            grant_idx <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                out_data  <= mux_dat;
                grant_idx <= win;
                last      <= win;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic,
// all checked against a behavioural round-robin model.
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [1:0]     grant_idx;

    int total = 0;
    int bad   = 0;

    // Model: is a word held, which word/index, who won last.
    bit m_full;
    int m_dat;
    int m_idx;
    int m_last;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_idx (grant_idx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_full = 1'b0;
        m_dat  = 0;
        m_idx  = 0;
        m_last = N - 1;
    endtask

    function automatic int m_pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check at the falling edge, advance model at the rising edge.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic ordy, input string tag);
        logic [N-1:0] exp_rdy;
        int           w;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        @(negedge clk);
        w       = m_pick(v);
        exp_rdy = '0;
        if (rst_n && (!m_full || ordy) && w >= 0) exp_rdy[w] = 1'b1;
        chk({tag, "_rdy"}, req_ready, exp_rdy);
        chk({tag, "_ov"},  out_valid, m_full);
        chk({tag, "_od"},  out_data,  m_dat);
        chk({tag, "_gi"},  grant_idx, m_idx);
        @(posedge clk);
        if (rst_n) begin
            if ((!m_full || ordy) && w >= 0) begin
                m_full = 1'b1;
                m_dat  = int'(d[w*W +: W]);
                m_idx  = w;
                m_last = w;
            end else if (m_full && ordy) begin
                m_full = 1'b0;
            end
        end
        #1;
    endtask

    logic [N*W-1:0] rr_dat;
    logic [N*W-1:0] rnd_dat;

    initial begin
        rr_dat    = 32'hA3A2A1A0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = rr_dat;
        out_ready = 1'b1;
        m_reset();

        // Reset then idle
        #2;
        chk("rst_ov", out_valid, 0);
        chk("rst_rdy", req_ready, 0);
        chk("rst_od", out_data, 0);
        step(4'b1111, rr_dat, 1'b1, "rst_hold");
        rst_n = 1'b1;

        // Round-robin over all four
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, rr_dat, 1'b1, "rr");
            chk("rr_seq_gi", grant_idx, i % 4);
            chk("rr_seq_od", out_data, 32'hA0 + (i % 4));
        end

        // Backpressure with the word from requester 0 held
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, rr_dat, 1'b0, "bp");
            chk("bp_gi", grant_idx, 0);
            chk("bp_od", out_data, 32'hA0);
            chk("bp_ov", out_valid, 1);
        end
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", req_ready, 4'b0010);
        step(4'b1111, rr_dat, 1'b1, "bp_rel");
        chk("bp_rel_gi", grant_idx, 1);

        // Skipping and wrap: make last = 2, then only 0 and 1 request
        step(4'b0100, rr_dat, 1'b1, "sk_set");
        chk("sk_set_gi", grant_idx, 2);
        step(4'b0011, rr_dat, 1'b1, "sk");
        chk("sk_w0", grant_idx, 0);
        step(4'b0011, rr_dat, 1'b1, "sk");
        chk("sk_w1", grant_idx, 1);
        step(4'b0011, rr_dat, 1'b1, "sk");
        chk("sk_w2", grant_idx, 0);

        // Drain to idle after a single word from requester 3
        step(4'b1000, 32'h5D000000, 1'b1, "dr_load");
        chk("dr_ov1", out_valid, 1);
        step(4'b0000, 32'h5D000000, 1'b1, "dr");
        chk("dr_ov0", out_valid, 0);
        chk("dr_od", out_data, 32'h5D);
        chk("dr_gi", grant_idx, 3);
        step(4'b0000, 32'h5D000000, 1'b1, "dr_idle");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rnd_dat = {$urandom};
            step(4'($urandom), rnd_dat, ($urandom_range(0, 3) != 0), "rnd");
        end

        // Reset asserted between edges mid-stream
        step(4'b1111, rr_dat, 1'b1, "mr_pre");
        step(4'b1111, rr_dat, 1'b1, "mr_pre");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_ov", out_valid, 0);
        chk("mr_rdy", req_ready, 0);
        chk("mr_od", out_data, 0);
        chk("mr_gi", grant_idx, 0);
        m_reset();
        step(4'b1111, rr_dat, 1'b1, "mr_hold");
        rst_n = 1'b1;
        step(4'b1111, rr_dat, 1'b1, "mr_post");
        chk("mr_first_gi", grant_idx, 0);
        chk("mr_first_od", out_data, 32'hA0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
